// File: rtl/piton_noc_arb_pkg.sv
// Shared types and helpers for the Piton NoC merge arbiter.
package piton_noc_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping within nreq requesters.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int unsigned        nreq);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = ({29'b0, ptr} + k) % nreq;
      if (k < nreq && !res.found && req[cand[2:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/piton_flit_fifo.sv
// Per-requester flit FIFO; a push into a full FIFO is accepted only alongside a pop.
module piton_flit_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piton_noc_merge_arbiter.sv
// Merges NREQ valid/yummy Piton injection channels onto one, round-robin and
// packet-atomic, with a downstream credit counter.
module piton_noc_merge_arbiter
  import piton_noc_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned OUT_CREDITS = 4,
  parameter int unsigned LEN_LSB     = 22,
  parameter int unsigned LEN_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ*DATA_W-1:0]   in_data,
  input  logic [NREQ-1:0]          in_valid,
  output logic [NREQ-1:0]          in_yummy,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_yummy,
  output logic [$clog2(NREQ)-1:0]  out_src,
  output logic                     out_head
);

  localparam int unsigned PTRw = $clog2(NREQ);
  localparam int unsigned CRw  = $clog2(OUT_CREDITS + 1);

  logic [DATA_W-1:0] fifo_dout [NREQ];
  logic [NREQ-1:0]   empty_vec, full_vec, pop_vec;

  arb_state_t        state_q, state_d;
  logic [PTRw-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [CRw-1:0]    credit_q, credit_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [PTRw-1:0]   out_src_q, out_src_d;
  logic              out_head_q, out_head_d;
  logic [NREQ-1:0]   in_yummy_q, in_yummy_d;

  logic              send, is_head;
  logic [PTRw-1:0]   sel;
  logic [LEN_W-1:0]  len;
  rr_pick_t          pick;

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    piton_flit_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid[i]),
      .pop   (pop_vec[i]),
      .din   (in_data[i*DATA_W +: DATA_W]),
      .dout  (fifo_dout[i]),
      .empty (empty_vec[i]),
      .full  (full_vec[i])
    );
  end

  function automatic logic [PTRw-1:0] next_ptr(input logic [PTRw-1:0] p);
    return (p == PTRw'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    credit_d    = credit_q;
    send        = 1'b0;
    is_head     = 1'b0;
    sel         = grant_q;
    len         = '0;
    pop_vec     = '0;
    pick        = rr_pick(MAX_REQ'(~empty_vec), 3'(rr_ptr_q), NREQ);

    case (state_q)
      IDLE: begin
        if (credit_q != '0 && pick.found) begin
          send    = 1'b1;
          is_head = 1'b1;
          sel     = PTRw'(pick.idx);
          len     = fifo_dout[sel][LEN_LSB +: LEN_W];
          if (len == '0) begin
            rr_ptr_d = next_ptr(sel);
          end else begin
            remaining_d = len;
            grant_d     = sel;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (credit_q != '0 && !empty_vec[grant_q]) begin
          send        = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(grant_q);
          end
        end
      end
      default: ;
    endcase

    if (send) begin
      pop_vec[sel] = 1'b1;
    end

    case ({send, out_yummy})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: ;
    endcase

    out_valid_d = send;
    out_data_d  = send ? fifo_dout[sel] : out_data_q;
    out_src_d   = send ? sel : out_src_q;
    out_head_d  = send ? is_head : out_head_q;
    in_yummy_d  = pop_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
      credit_q    <= CRw'(OUT_CREDITS);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      out_head_q  <= 1'b0;
      in_yummy_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      remaining_q <= remaining_d;
      credit_q    <= credit_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_head_q  <= out_head_d;
      in_yummy_q  <= in_yummy_d;
    end
  end

  // Protocol checks: upstream overrunning a FIFO, downstream over-returning credit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((in_valid & full_vec & ~pop_vec) == '0);
      assert (!(out_yummy && !send && credit_q == CRw'(OUT_CREDITS)));
      assert (!(send && credit_q == '0));
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign out_head  = out_head_q;
  assign in_yummy  = in_yummy_q;

endmodule
